// File: rtl/ram_2r1w_port_bridge.sv
// rtl/ram_2r1w_port_bridge.sv - valid/ready request ports bridged onto a 2-read/1-write simulation RAM
//
// Purpose: converts an instruction-fetch read port (IF) and a load/store port
// (LS) into index-based accesses of a RAM with combinational read data and
// a clock-edge write. Each port holds at most one request in flight and
// returns its response a fixed LATENCY cycles after acceptance, flagging
// byte addresses outside [BASE_ADDR, BASE_ADDR + RAM_BYTES).
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   if_req_*  / if_resp_*           IF request (valid/ready/addr) and response (valid/ready/rdata/err)
//   ls_req_*  / ls_resp_*           LS request (valid/ready/addr/wen/wdata/wstrb) and response
//   ram_en                          RAM enable, low only while reset is asserted
//   ram_rIdx_0 / ram_rdata_0        RAM read port 0, owned by IF
//   ram_rIdx_1 / ram_rdata_1        RAM read port 1, owned by LS
//   ram_wIdx/wdata/wmask/wen        RAM write port, owned by LS
module ram_2r1w_port_bridge #(
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter logic [63:0] RAM_BYTES = 64'h0800_0000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_req_addr,
    output logic        if_resp_valid,
    input  logic        if_resp_ready,
    output logic [63:0] if_resp_rdata,
    output logic        if_resp_err,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [63:0] ls_req_addr,
    input  logic        ls_req_wen,
    input  logic [63:0] ls_req_wdata,
    input  logic [7:0]  ls_req_wstrb,
    output logic        ls_resp_valid,
    input  logic        ls_resp_ready,
    output logic [63:0] ls_resp_rdata,
    output logic        ls_resp_err,
    output logic        ram_en,
    output logic [63:0] ram_rIdx_0,
    input  logic [63:0] ram_rdata_0,
    output logic [63:0] ram_rIdx_1,
    input  logic [63:0] ram_rdata_1,
    output logic [63:0] ram_wIdx,
    output logic [63:0] ram_wdata,
    output logic [63:0] ram_wmask,
    output logic        ram_wen
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    // Address decode. BASE_ADDR and RAM_BYTES are 8-byte multiples, so the
    // low three address bits cannot change the range result and the shift
    // drops them from the index.
    logic [63:0] w_if_off;
    logic [63:0] w_ls_off;
    logic        w_if_in;
    logic        w_ls_in;

    assign w_if_off = if_req_addr - BASE_ADDR;
    assign w_ls_off = ls_req_addr - BASE_ADDR;
    assign w_if_in  = (if_req_addr >= BASE_ADDR) && (w_if_off < RAM_BYTES);
    assign w_ls_in  = (ls_req_addr >= BASE_ADDR) && (w_ls_off < RAM_BYTES);

    assign ram_en     = ~reset;
    assign ram_rIdx_0 = w_if_off >> 3;
    assign ram_rIdx_1 = w_ls_off >> 3;
    assign ram_wIdx   = w_ls_off >> 3;
    assign ram_wdata  = ls_req_wdata;

    logic [63:0] w_wmask;
    always_comb begin
        w_wmask = '0;
        for (int i = 0; i < 8; i++) begin
            w_wmask[i*8 +: 8] = {8{ls_req_wstrb[i]}};
        end
    end
    assign ram_wmask = w_wmask;

    // ---------------- IF port ----------------
    state_t      r_if_state;
    state_t      w_if_next;
    logic [7:0]  r_if_cnt;
    logic [63:0] r_if_rdata;
    logic        r_if_err;
    logic        w_if_ready;
    logic        w_if_acc;

    assign w_if_acc = if_req_valid & w_if_ready;

    always_comb begin
        w_if_next  = r_if_state;
        w_if_ready = 1'b0;
        case (r_if_state)
            S_IDLE: begin
                w_if_ready = ~reset;
                if (if_req_valid && !reset) begin
                    w_if_next = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_if_cnt == 8'd1) begin
                    w_if_next = S_RESP;
                end
            end
            S_RESP: begin
                if (if_resp_ready) begin
                    w_if_next = S_IDLE;
                end
            end
            default: w_if_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_state <= S_IDLE;
            r_if_cnt   <= 8'd0;
            r_if_rdata <= 64'd0;
            r_if_err   <= 1'b0;
        end else begin
            r_if_state <= w_if_next;
            if (w_if_acc) begin
                r_if_cnt   <= LAT_M1;
                r_if_rdata <= w_if_in ? ram_rdata_0 : 64'd0;
                r_if_err   <= ~w_if_in;
            end else if (r_if_state == S_WAIT) begin
                r_if_cnt <= r_if_cnt - 8'd1;
            end
        end
    end

    assign if_req_ready  = w_if_ready;
    assign if_resp_valid = (r_if_state == S_RESP);
    assign if_resp_rdata = r_if_rdata;
    assign if_resp_err   = r_if_err;

    // ---------------- LS port ----------------
    state_t      r_ls_state;
    state_t      w_ls_next;
    logic [7:0]  r_ls_cnt;
    logic [63:0] r_ls_rdata;
    logic        r_ls_err;
    logic        w_ls_ready;
    logic        w_ls_acc;

    assign w_ls_acc = ls_req_valid & w_ls_ready;

    always_comb begin
        w_ls_next  = r_ls_state;
        w_ls_ready = 1'b0;
        case (r_ls_state)
            S_IDLE: begin
                w_ls_ready = ~reset;
                if (ls_req_valid && !reset) begin
                    w_ls_next = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_ls_cnt == 8'd1) begin
                    w_ls_next = S_RESP;
                end
            end
            S_RESP: begin
                if (ls_resp_ready) begin
                    w_ls_next = S_IDLE;
                end
            end
            default: w_ls_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ls_state <= S_IDLE;
            r_ls_cnt   <= 8'd0;
            r_ls_rdata <= 64'd0;
            r_ls_err   <= 1'b0;
        end else begin
            r_ls_state <= w_ls_next;
            if (w_ls_acc) begin
                r_ls_cnt   <= LAT_M1;
                // Writes and out-of-range accesses always return zero data.
                r_ls_rdata <= (w_ls_in && !ls_req_wen) ? ram_rdata_1 : 64'd0;
                r_ls_err   <= ~w_ls_in;
            end else if (r_ls_state == S_WAIT) begin
                r_ls_cnt <= r_ls_cnt - 8'd1;
            end
        end
    end

    // The write commits at the accept edge, so a same-cycle IF read of the
    // same index still captures the old word.
    assign ram_wen       = w_ls_acc & ls_req_wen & w_ls_in;
    assign ls_req_ready  = w_ls_ready;
    assign ls_resp_valid = (r_ls_state == S_RESP);
    assign ls_resp_rdata = r_ls_rdata;
    assign ls_resp_err   = r_ls_err;

endmodule

// File: tb/tb_ram_2r1w_port_bridge.sv
// tb/tb_ram_2r1w_port_bridge.sv - bench for ram_2r1w_port_bridge at LATENCY 1 and 4
module tb_ram_2r1w_port_bridge;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [63:0] BYTES = 64'h200;
    localparam int          NW    = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] reset, if_req_valid, if_req_ready, if_resp_valid, if_resp_ready, if_resp_err;
    logic [1:0] ls_req_valid, ls_req_ready, ls_req_wen, ls_resp_valid, ls_resp_ready, ls_resp_err;
    logic [1:0] ram_en, ram_wen;
    logic [1:0][63:0] if_req_addr, if_resp_rdata, ls_req_addr, ls_req_wdata, ls_resp_rdata;
    logic [1:0][63:0] ram_rIdx_0, ram_rdata_0, ram_rIdx_1, ram_rdata_1, ram_wIdx, ram_wdata, ram_wmask;
    logic [1:0][7:0]  ls_req_wstrb;
    logic             mem_init;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] model [2][NW];

    function automatic logic [63:0] init_val(input int i);
        if (i == 1) return 64'hDEAD;
        return {16'hA5A5, 48'(i)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [63:0] mem [NW];

        ram_2r1w_port_bridge #(
            .BASE_ADDR(BASE),
            .RAM_BYTES(BYTES),
            .LATENCY  ((g == 0) ? 1 : 4)
        ) u_dut (
            .clk          (clk),
            .reset        (reset[g]),
            .if_req_valid (if_req_valid[g]),
            .if_req_ready (if_req_ready[g]),
            .if_req_addr  (if_req_addr[g]),
            .if_resp_valid(if_resp_valid[g]),
            .if_resp_ready(if_resp_ready[g]),
            .if_resp_rdata(if_resp_rdata[g]),
            .if_resp_err  (if_resp_err[g]),
            .ls_req_valid (ls_req_valid[g]),
            .ls_req_ready (ls_req_ready[g]),
            .ls_req_addr  (ls_req_addr[g]),
            .ls_req_wen   (ls_req_wen[g]),
            .ls_req_wdata (ls_req_wdata[g]),
            .ls_req_wstrb (ls_req_wstrb[g]),
            .ls_resp_valid(ls_resp_valid[g]),
            .ls_resp_ready(ls_resp_ready[g]),
            .ls_resp_rdata(ls_resp_rdata[g]),
            .ls_resp_err  (ls_resp_err[g]),
            .ram_en       (ram_en[g]),
            .ram_rIdx_0   (ram_rIdx_0[g]),
            .ram_rdata_0  (ram_rdata_0[g]),
            .ram_rIdx_1   (ram_rIdx_1[g]),
            .ram_rdata_1  (ram_rdata_1[g]),
            .ram_wIdx     (ram_wIdx[g]),
            .ram_wdata    (ram_wdata[g]),
            .ram_wmask    (ram_wmask[g]),
            .ram_wen      (ram_wen[g])
        );

        assign ram_rdata_0[g] = (ram_rIdx_0[g] < 64'(NW)) ? mem[ram_rIdx_0[g][5:0]] : 64'hBAD0_BAD0_BAD0_BAD0;
        assign ram_rdata_1[g] = (ram_rIdx_1[g] < 64'(NW)) ? mem[ram_rIdx_1[g][5:0]] : 64'hBAD1_BAD1_BAD1_BAD1;

        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < NW; i++) mem[i] <= init_val(i);
            end else if (ram_wen[g] && ram_wIdx[g] < 64'(NW)) begin
                mem[ram_wIdx[g][5:0]] <= (mem[ram_wIdx[g][5:0]] & ~ram_wmask[g]) | (ram_wdata[g] & ram_wmask[g]);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit in_range(input logic [63:0] addr);
        return (addr >= BASE) && (addr < BASE + BYTES);
    endfunction

    function automatic void ref_resp(input int g, input logic [63:0] addr, input bit wen,
                                     output logic [63:0] rd, output bit er);
        er = !in_range(addr);
        rd = (in_range(addr) && !wen) ? model[g][int'((addr - BASE) / 8)] : 64'd0;
    endfunction

    task automatic transact(input int g, input bit is_ls, input logic [63:0] addr, input bit wen,
                            input logic [63:0] wdata, input logic [7:0] wstrb, input int hold,
                            input logic [63:0] exp_rdata, input bit exp_err, input string tag);
        logic [63:0] exp_idx, exp_mask, rd;
        bit          do_wr, any_wen, any_rdy, vld, er, unstable;
        int          lat, exp_lat;
        exp_idx = (addr - BASE) / 8;
        do_wr   = is_ls && wen && in_range(addr);
        exp_lat = (g == 0) ? 1 : 4;
        for (int b = 0; b < 8; b++) exp_mask[b*8 +: 8] = wstrb[b] ? 8'hFF : 8'h00;

        @(negedge clk);
        if (is_ls) begin
            ls_req_valid[g] = 1'b1; ls_req_addr[g] = addr; ls_req_wen[g] = wen;
            ls_req_wdata[g] = wdata; ls_req_wstrb[g] = wstrb;
        end else begin
            if_req_valid[g] = 1'b1; if_req_addr[g] = addr;
        end
        #1;
        chk({tag, " req_ready"}, 64'(is_ls ? ls_req_ready[g] : if_req_ready[g]), 64'd1);
        chk({tag, " rIdx"}, is_ls ? ram_rIdx_1[g] : ram_rIdx_0[g], exp_idx);
        if (is_ls) chk({tag, " ram_wen"}, 64'(ram_wen[g]), 64'(do_wr));
        if (do_wr) begin
            chk({tag, " wIdx"}, ram_wIdx[g], exp_idx);
            chk({tag, " wdata"}, ram_wdata[g], wdata);
            chk({tag, " wmask"}, ram_wmask[g], exp_mask);
        end
        @(posedge clk);
        @(negedge clk);
        lat     = 1;
        vld     = is_ls ? ls_resp_valid[g] : if_resp_valid[g];
        any_wen = ram_wen[g];
        any_rdy = is_ls ? ls_req_ready[g] : if_req_ready[g];
        if_req_valid[g] = 1'b0; ls_req_valid[g] = 1'b0; ls_req_wen[g] = 1'b0;
        while (!vld && lat < 300) begin
            @(negedge clk);
            lat++;
            vld     = is_ls ? ls_resp_valid[g] : if_resp_valid[g];
            any_wen |= ram_wen[g];
            any_rdy |= is_ls ? ls_req_ready[g] : if_req_ready[g];
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        rd = is_ls ? ls_resp_rdata[g] : if_resp_rdata[g];
        er = is_ls ? ls_resp_err[g] : if_resp_err[g];
        chk({tag, " rdata"}, rd, exp_rdata);
        chk({tag, " err"}, 64'(er), 64'(exp_err));
        unstable = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            if ((is_ls ? ls_resp_valid[g] : if_resp_valid[g]) !== 1'b1 ||
                (is_ls ? ls_resp_rdata[g] : if_resp_rdata[g]) !== rd ||
                (is_ls ? ls_resp_err[g] : if_resp_err[g]) !== er) unstable = 1'b1;
            any_wen |= ram_wen[g];
            any_rdy |= is_ls ? ls_req_ready[g] : if_req_ready[g];
        end
        chk({tag, " hold_stable"}, 64'(unstable), 64'd0);
        chk({tag, " extra_wen"}, 64'(any_wen), 64'd0);
        chk({tag, " busy_ready"}, 64'(any_rdy), 64'd0);
        if (is_ls) ls_resp_ready[g] = 1'b1; else if_resp_ready[g] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ls_resp_ready[g] = 1'b0; if_resp_ready[g] = 1'b0;
        #1;
        chk({tag, " resp_done"}, 64'(is_ls ? ls_resp_valid[g] : if_resp_valid[g]), 64'd0);
        chk({tag, " ready_again"}, 64'(is_ls ? ls_req_ready[g] : if_req_ready[g]), 64'd1);
        if (do_wr) begin
            for (int b = 0; b < 8; b++)
                if (wstrb[b]) model[g][int'(exp_idx)][b*8 +: 8] = wdata[b*8 +: 8];
        end
    endtask

    typedef struct {
        int          g;
        bit          is_ls;
        logic [63:0] addr;
        bit          wen;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        int          hold;
        logic [63:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vt [11];
        logic [63:0] rd, addr, wdata;
        bit          er, any_v, is_ls, wen;
        int          g, sel;

        vt[0]  = '{0, 1'b0, BASE + 64'h8,   1'b0, 64'h0, 8'h00, 0, 64'hDEAD, 1'b0};
        vt[1]  = '{0, 1'b1, BASE + 64'h10,  1'b1, 64'h1122_3344_5566_7788, 8'h0F, 0, 64'h0, 1'b0};
        vt[2]  = '{0, 1'b1, BASE + 64'h10,  1'b0, 64'h0, 8'h00, 1, 64'hA5A5_0000_5566_7788, 1'b0};
        vt[3]  = '{0, 1'b1, 64'h7FFF_FFF8,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 64'h0, 1'b1};
        vt[4]  = '{0, 1'b1, BASE + BYTES,   1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 64'h0, 1'b1};
        vt[5]  = '{0, 1'b0, BASE + BYTES,   1'b0, 64'h0, 8'h00, 0, 64'h0, 1'b1};
        vt[6]  = '{0, 1'b0, BASE + BYTES - 64'h1, 1'b0, 64'h0, 8'h00, 0, 64'hA5A5_0000_0000_003F, 1'b0};
        vt[7]  = '{1, 1'b1, BASE + 64'h18,  1'b0, 64'h0, 8'h00, 3, 64'hA5A5_0000_0000_0003, 1'b0};
        vt[8]  = '{1, 1'b0, BASE + 64'h27,  1'b0, 64'h0, 8'h00, 0, 64'hA5A5_0000_0000_0004, 1'b0};
        vt[9]  = '{1, 1'b1, BASE + 64'h40,  1'b1, 64'h0102_0304_0506_07F0, 8'h81, 0, 64'h0, 1'b0};
        vt[10] = '{1, 1'b0, BASE + 64'h40,  1'b0, 64'h0, 8'h00, 2, 64'h01A5_0000_0000_00F0, 1'b0};

        reset = 2'b11; mem_init = 1'b1;
        if_req_valid = '0; if_req_addr = '0; if_resp_ready = '0;
        ls_req_valid = '0; ls_req_addr = '0; ls_req_wen = '0; ls_req_wdata = '0; ls_req_wstrb = '0;
        ls_resp_ready = '0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NW; i++) model[k][i] = init_val(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst if_req_ready", 64'(if_req_ready[k]), 64'd0);
            chk("rst ls_req_ready", 64'(ls_req_ready[k]), 64'd0);
            chk("rst resp_valid", 64'({if_resp_valid[k], ls_resp_valid[k]}), 64'd0);
            chk("rst if_rdata", if_resp_rdata[k], 64'd0);
            chk("rst ls_rdata", ls_resp_rdata[k], 64'd0);
            chk("rst err", 64'({if_resp_err[k], ls_resp_err[k]}), 64'd0);
            chk("rst ram_wen", 64'(ram_wen[k]), 64'd0);
            chk("rst ram_en", 64'(ram_en[k]), 64'd0);
        end
        reset = 2'b00; mem_init = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("post_rst ram_en", 64'(ram_en[k]), 64'd1);
            chk("post_rst ready", 64'({if_req_ready[k], ls_req_ready[k]}), 64'd3);
        end

        for (int v = 0; v < 11; v++)
            transact(vt[v].g, vt[v].is_ls, vt[v].addr, vt[v].wen, vt[v].wdata, vt[v].wstrb,
                     vt[v].hold, vt[v].exp_rdata, vt[v].exp_err, $sformatf("vec%0d", v));

        // Same-cycle IF read and LS write of index 5: IF sees the old word.
        @(negedge clk);
        if_req_valid[0] = 1'b1; if_req_addr[0] = BASE + 64'h28;
        ls_req_valid[0] = 1'b1; ls_req_addr[0] = BASE + 64'h28; ls_req_wen[0] = 1'b1;
        ls_req_wdata[0] = 64'hCAFE_F00D_1234_5678; ls_req_wstrb[0] = 8'hFF;
        #1;
        chk("race ram_wen", 64'(ram_wen[0]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        if_req_valid[0] = 1'b0; ls_req_valid[0] = 1'b0; ls_req_wen[0] = 1'b0;
        #1;
        chk("race if_valid", 64'(if_resp_valid[0]), 64'd1);
        chk("race if_old_data", if_resp_rdata[0], 64'hA5A5_0000_0000_0005);
        chk("race ls_valid", 64'(ls_resp_valid[0]), 64'd1);
        chk("race ls_rdata", ls_resp_rdata[0], 64'd0);
        if_resp_ready[0] = 1'b1; ls_resp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if_resp_ready[0] = 1'b0; ls_resp_ready[0] = 1'b0;
        model[0][5] = 64'hCAFE_F00D_1234_5678;
        transact(0, 1'b0, BASE + 64'h28, 1'b0, 64'h0, 8'h00, 0, 64'hCAFE_F00D_1234_5678, 1'b0, "race_reread");

        // Reset while LS is waiting: the request is dropped silently.
        @(negedge clk);
        ls_req_valid[1] = 1'b1; ls_req_addr[1] = BASE + 64'h30; ls_req_wen[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ls_req_valid[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst resp_valid", 64'(ls_resp_valid[1]), 64'd0);
        chk("midrst req_ready", 64'(ls_req_ready[1]), 64'd0);
        chk("midrst ram_en", 64'(ram_en[1]), 64'd0);
        reset[1] = 1'b0;
        any_v = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            any_v |= ls_resp_valid[1];
        end
        chk("midrst no_resp", 64'(any_v), 64'd0);
        chk("midrst ready", 64'(ls_req_ready[1]), 64'd1);
        transact(1, 1'b1, BASE + 64'h30, 1'b0, 64'h0, 8'h00, 1, model[1][6], 1'b0, "midrst_fresh");

        // Randomized traffic checked against the array model.
        for (int n = 0; n < 60; n++) begin
            g     = int'($urandom_range(0, 1));
            is_ls = 1'($urandom_range(0, 1));
            wen   = is_ls & 1'($urandom_range(0, 1));
            sel   = int'($urandom_range(0, 9));
            if (sel == 0)      addr = BASE - 64'(8 * $urandom_range(1, 4));
            else if (sel == 1) addr = BASE + BYTES + 64'(8 * $urandom_range(0, 3));
            else               addr = BASE + 64'($urandom_range(0, 511));
            wdata = {$urandom, $urandom};
            ref_resp(g, addr, wen, rd, er);
            transact(g, is_ls, addr, wen, wdata, 8'($urandom_range(0, 255)),
                     int'($urandom_range(0, 2)), rd, er, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
